// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-memory fetch controller: state encoding,
// memory geometry and the PC alignment/range check.
package imem_fetch_ctrl_pkg;

    localparam int unsigned IMEM_BYTES  = 4096;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    // True when pc cannot address a whole word inside a memory of mem_bytes bytes.
    function automatic logic pc_fault(input logic [31:0] pc, input logic [31:0] mem_bytes);
        return (pc[1:0] != 2'b00) || (pc > (mem_bytes - 32'(INSTR_BYTES)));
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory port owner: arbitrates loader byte writes (halted) against
// CPU word fetches (running), tracks the PC and presents instructions to decode.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              run,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_gnt,
    output logic [ADDR_W:0]   ld_count,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [31:0]       pc_out,
    output logic              fault,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam logic [31:0] MEM_BYTES = 32'(1) << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    fetch_state_e     state, state_nxt;
    logic [31:0]      pc, pc_nxt;
    logic [31:0]      instr_nxt, pc_out_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next-state, datapath updates and memory-port decode.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = instr;
        pc_out_nxt = pc_out;
        cnt_nxt    = ld_count;
        ld_gnt     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc[ADDR_W-1:0];
        mem_wdata  = 8'h00;

        unique case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_ISSUE;
                end else if (ld_req) begin
                    ld_gnt    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_data;
                    if (ld_count != CNT_MAX) begin
                        cnt_nxt = ld_count + CNT_W'(1);
                    end
                end
            end
            ST_ISSUE: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                end else if (pc_fault(pc, MEM_BYTES)) begin
                    state_nxt = ST_FAULT;
                end else begin
                    mem_re    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_ISSUE;
                end else begin
                    instr_nxt  = mem_rdata;
                    pc_out_nxt = pc;
                    state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_ISSUE;
                end else if (instr_ready) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Strobes drop the moment reset asserts, without waiting for a clock.
        if (!reset_n) begin
            ld_gnt = 1'b0;
            mem_re = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            pc_out      <= 32'h0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            ld_count    <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            pc_out      <= pc_out_nxt;
            instr_valid <= (state_nxt == ST_HOLD);
            fault       <= (state_nxt == ST_FAULT);
            ld_count    <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed scenarios followed by random
// stimulus, checked against a transaction-level fetch model.
module tb_imem_fetch_ctrl;

    localparam int unsigned AW = 12;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          run = 1'b0;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = '0;
    logic          ld_gnt;
    logic [AW:0]   ld_count;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          instr_ready = 1'b0;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [31:0]   pc_out;
    logic          fault;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [31:0]   mem_rdata = '0;

    imem_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset_n(reset_n), .run(run),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_gnt(ld_gnt), .ld_count(ld_count),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_ready(instr_ready), .instr_valid(instr_valid),
        .instr(instr), .pc_out(pc_out), .fault(fault),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 90) ^ (i >> 3));
    endfunction

    // Memory attached to the DUT port; one-cycle read latency.
    logic [7:0] tbmem [4096];
    initial begin
        for (int i = 0; i < 4096; i++) tbmem[i] = init_byte(i);
        forever begin
            @(posedge clock);
            if (mem_we) tbmem[mem_addr] = mem_wdata;
            if (mem_re) mem_rdata <= {tbmem[mem_addr], tbmem[mem_addr + 12'd1],
                                      tbmem[mem_addr + 12'd2], tbmem[mem_addr + 12'd3]};
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural PC plus fetch progress measured in cycles.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t q[$];
    exp_t cur;

    logic [7:0]  mmem [4096];
    logic [31:0] m_pc;
    bit          m_idle;
    bit          m_fault;
    int          m_age;
    int          m_cnt;

    function automatic bit model_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a <= 32'd4092);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return {mmem[a], mmem[a + 1], mmem[a + 2], mmem[a + 3]};
    endfunction

    function automatic bit m_valid();
        return !m_fault && !m_idle && (m_age == 2);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_idle = 1; m_fault = 0; m_age = 0; m_cnt = 0;
        q.delete();
    endtask

    task automatic model_tick(input bit r, input bit ldq, input logic [11:0] la, input logic [7:0] ld,
                              input bit rv, input logic [31:0] rpc, input bit rdy);
        exp_t e;
        if (m_fault) return;
        if (m_idle) begin
            if (r) begin
                m_idle = 0; m_age = 0;
            end else if (ldq) begin
                mmem[la] = ld;
                if (m_cnt < 4096) m_cnt++;
            end
        end else if (!r) begin
            m_idle = 1;
        end else if (rv) begin
            m_pc = rpc; m_age = 0;
        end else if (m_age == 0) begin
            if (!model_ok(m_pc)) m_fault = 1;
            else m_age = 1;
        end else if (m_age == 1) begin
            m_age = 2;
            e.pc = m_pc; e.word = model_word(m_pc);
            q.push_back(e);
        end else if (rdy) begin
            m_pc = m_pc + 32'd4; m_age = 0;
        end
    endtask

    // One clock: drive at negedge, check the combinational port, advance model, check state.
    task automatic step(input bit r, input bit ldq, input logic [11:0] la, input logic [7:0] ld,
                        input bit rv, input logic [31:0] rpc, input bit rdy);
        bit g, re;
        @(negedge clock);
        run = r; ld_req = ldq; ld_addr = la; ld_data = ld;
        redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
        #1;
        g  = !m_fault && m_idle && !r && ldq;
        re = !m_fault && !m_idle && (m_age == 0) && r && !rv && model_ok(m_pc);
        chk("ld_gnt", ld_gnt, g);
        chk("mem_we", mem_we, g);
        chk("mem_re", mem_re, re);
        if (g) begin
            chk("wr_addr", mem_addr, la);
            chk("wr_data", mem_wdata, ld);
        end
        if (re) chk("rd_addr", mem_addr, m_pc[11:0]);
        @(posedge clock);
        model_tick(r, ldq, la, ld, rv, rpc, rdy);
        #1;
        chk("instr_valid", instr_valid, m_valid());
        chk("fault", fault, m_fault);
        chk("ld_count", ld_count, 64'(m_cnt));
    endtask

    task automatic run_step(input bit rdy);
        step(1, 0, 12'h0, 8'h0, 0, 32'h0, rdy);
    endtask

    // Asserts reset between clock edges and checks that outputs clear without a clock.
    task automatic async_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_count", ld_count, 13'h0);
        chk("rst_mem_re", mem_re, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_ld_gnt", ld_gnt, 1'b0);
        model_reset();
        run = 0; ld_req = 0; redirect_valid = 0; instr_ready = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Monitor: pops an expected entry each time a new instruction is presented.
    initial begin
        bit prev_v = 0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset_n) begin
                prev_v = 0;
            end else begin
                if (instr_valid && !prev_v) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_instr: got pc_out=%0h instr=%0h want none", pc_out, instr);
                    end else begin
                        cur = q.pop_front();
                        chk("pc_out", pc_out, cur.pc);
                        chk("instr", instr, cur.word);
                    end
                end else if (instr_valid) begin
                    chk("hold_pc_out", pc_out, cur.pc);
                    chk("hold_instr", instr, cur.word);
                end
                prev_v = instr_valid;
            end
        end
    end

    initial begin
        bit r, ldq, rv, rdy;
        logic [11:0] la;
        logic [7:0] ld;
        logic [31:0] rpc;
        int fc;
        for (int i = 0; i < 4096; i++) mmem[i] = init_byte(i);
        model_reset();
        #12;
        chk("reset_valid", instr_valid, 1'b0);
        chk("reset_fault", fault, 1'b0);
        chk("reset_pc_out", pc_out, 32'h0);
        chk("reset_mem_re", mem_re, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        // Load one big-endian word, then fetch it.
        for (int i = 0; i < 4; i++) step(0, 1, 12'(i), 8'(i * 17), 0, 32'h0, 0);
        chk("count_after_load", ld_count, 13'd4);
        for (int i = 0; i < 4; i++) run_step(0);
        chk("first_instr", instr, 32'h0011_2233);
        chk("first_pc_out", pc_out, 32'h0);

        // Streaming fetch, a long stall, then redirect that overrides ready.
        for (int i = 0; i < 8; i++) run_step(1);
        for (int i = 0; i < 6; i++) run_step(0);
        step(1, 0, 12'h0, 8'h0, 1, 32'h40, 1);
        for (int i = 0; i < 3; i++) run_step(0);
        chk("redirect_pc_out", pc_out, 32'h40);

        // Misaligned redirect: sticky fault, loader locked out.
        step(1, 0, 12'h0, 8'h0, 1, 32'h42, 0);
        for (int i = 0; i < 2; i++) run_step(0);
        for (int i = 0; i < 3; i++) step(0, 1, 12'h10, 8'hEE, 0, 32'h0, 0);
        chk("fault_sticky", fault, 1'b1);
        async_reset();

        // Last word of memory, then wrap to 0x1000 faults.
        for (int i = 0; i < 6 && !m_valid(); i++) run_step(0);
        step(1, 0, 12'h0, 8'h0, 1, 32'hFFC, 1);
        for (int i = 0; i < 8; i++) run_step(1);
        chk("fault_wrap", fault, 1'b1);
        async_reset();

        // Halt during WAIT, load a byte, resume, then reset mid-HOLD.
        for (int i = 0; i < 6 && !(m_age == 1 && !m_idle); i++) run_step(0);
        step(0, 0, 12'h0, 8'h0, 0, 32'h0, 0);
        step(0, 1, 12'h8, 8'hA5, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) run_step(0);
        chk("resume_pc_out", pc_out, 32'h0);
        for (int i = 0; i < 8; i++) run_step(1);
        for (int i = 0; i < 6 && !m_valid(); i++) run_step(0);
        async_reset();

        // Random traffic.
        fc = 0;
        for (int c = 0; c < 2000; c++) begin
            if (m_fault) begin
                fc++;
                if (fc > 3) begin
                    async_reset();
                    fc = 0;
                end
            end
            r   = ($urandom_range(0, 9) != 0);
            ldq = $urandom_range(0, 1) != 0;
            la  = 12'($urandom);
            ld  = 8'($urandom);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? $urandom : {20'h0, 10'($urandom), 2'b00};
            rdy = ($urandom_range(0, 2) != 0);
            step(r, ldq, la, ld, rv, rpc, rdy);
        end

        repeat (2) @(posedge clock);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_expected: got %0d unpresented want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencing and arbitration controller for the 4 KB byte-addressed instruction memory. It owns the single memory port and shares it between a program loader, which writes bytes while the CPU is halted, and the CPU fetch path, which reads big-endian 32-bit words at the PC. It holds the PC, handles redirects (branch/jump) and alignment/range faults, and presents each fetched instruction through a valid/ready handshake to the decode stage.

## Interface
- ADDR_W, 12, memory byte-address width (4096 bytes)
- RESET_PC, 32'h0, PC value loaded on reset
- clock  in  1  single clock, all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  1 = CPU fetch owns memory; 0 = halted, loader owns memory
- ld_req  in  1  loader byte-write request
- ld_addr  in  ADDR_W  loader byte address
- ld_data  in  8  loader byte
- ld_gnt  out  1  loader write accepted this cycle
- ld_count  out  ADDR_W+1  bytes written since reset, saturating at 4096
- redirect_valid  in  1  load new PC
- redirect_pc  in  32  redirect target
- instr_ready  in  1  decode accepts the presented instruction
- instr_valid  out  1  instr/pc_out valid
- instr  out  32  fetched word
- pc_out  out  32  address of instr
- fault  out  1  sticky misaligned/out-of-range PC fault
- mem_re, mem_we  out  1  memory read / byte-write strobe
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  32  {m[a],m[a+1],m[a+2],m[a+3]}, valid the cycle after mem_re

## Operation
- States: IDLE, ISSUE, WAIT, HOLD, FAULT. Reset: state IDLE, pc=RESET_PC, instr=0, pc_out=0, instr_valid=0, fault=0, ld_count=0, all mem strobes 0.
- IDLE: ld_gnt = ld_req (combinational); when granted, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data, ld_count++ (saturating). run=1 -> ISSUE (takes priority; ld_gnt=0 in that cycle).
- ISSUE: pc checked first: pc[1:0]!=0 or pc[31:ADDR_W]!=0 or pc[ADDR_W-1:0]>4092 -> FAULT. Otherwise mem_re=1, mem_addr=pc[ADDR_W-1:0] -> WAIT.
- WAIT: instr<=mem_rdata, pc_out<=pc -> HOLD.
- HOLD: instr_valid=1; instr/pc_out stable. instr_ready=1 -> pc<=pc+4, state ISSUE (instr_valid low next cycle).
- redirect_valid in ISSUE/WAIT/HOLD: pc<=redirect_pc, in-flight read discarded (instr unchanged), instr_valid 0 next cycle, -> ISSUE. Overrides instr_ready in the same cycle. Ignored in IDLE and FAULT.
- run=0 in ISSUE/WAIT/HOLD: -> IDLE next cycle, pc kept, in-flight read discarded, instr_valid 0. run outranks redirect; resuming re-fetches the saved pc.
- FAULT: fault=1, instr_valid=0, no memory access, loader not granted; exits only on reset.
- Loader requests while state != IDLE: ld_gnt=0, no write.
- pc+4 is 32-bit wrap; wrap past 4092 faults at next ISSUE.

## Timing
- Fetch latency: ISSUE at cycle n, instr_valid at n+2. Sustained throughput with instr_ready held 1: one instruction per 3 cycles.
- Loader: one byte per cycle while IDLE and ld_req=1; zero-latency grant.
- redirect_valid at cycle n -> mem_re for redirect_pc at n+1, instr_valid at n+3.
- reset_n assertion mid-operation clears all state immediately, no clock needed; mem_we/mem_re deassert asynchronously.
- All outputs except ld_gnt, mem_* strobes/address/wdata are registered; mem_* decode from state and inputs.

## Structure
- Shared package: state encoding (IDLE, ISSUE, WAIT, HOLD, FAULT), INSTR_BYTES=4, default RESET_PC, IMEM_BYTES=4096.
- Single module; no sub-module needed. Range/alignment check is a combinational function in the package.

## Test plan
- Reset, run=0, load bytes 0x00,0x11,0x22,0x33 at 0..3 -> ld_gnt each cycle, ld_count=4; run=1 -> instr=32'h00112233, pc_out=0 two cycles after ISSUE.
- run=1, instr_ready=1 over words at 0,4,8 -> pc_out 0,4,8, instr_valid high every third cycle, each word big-endian.
- Hold instr_ready=0 for 5 cycles in HOLD -> instr/pc_out stable; redirect_valid with instr_ready=1 same cycle to 0x40 -> next pc_out=0x40, no pc_out=4.
- redirect_pc=0x42 -> FAULT, fault=1, no further mem_re; ld_req ignored; only reset_n clears fault.
- redirect_pc=0xFFC then ready -> instr from 0xFFC, then pc=0x1000 -> fault=1.
- Drop run during WAIT -> instr_valid stays 0, loader write at addr 8 granted, run=1 re-fetches saved pc; assert reset_n mid-HOLD -> instr_valid=0 immediately, pc=RESET_PC.
